// File: rtl/uart_tx.sv
// uart_tx -- parameterised UART transmitter with a one-entry holding register.
//
// Ports
//   clk        system clock, all logic on its rising edge
//   reset      asynchronous, active-high reset
//   baudclk    bit-rate clock (already in the clk domain, 50% duty); one bit
//              period is one full baudclk cycle
//   tx_data    DATA_BITS-wide word to send, LSB first
//   tx_valid   tx_data is valid
//   tx_ready   holding register empty (= ~hold_full)
//   txd        registered serial line, idles high
//   tx_busy    high whenever the FSM is not in IDLE
//   state_dbg  current FSM state (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//
// Handshake: a word is taken on any clk edge where tx_valid & tx_ready are
// both high; no baud tick is needed. tx_data is copied into the holding
// register and tx_ready drops on the following cycle. While tx_ready is low
// tx_data and tx_valid are ignored. tx_ready returns high when the FSM moves
// the held word into the shift register at the start of its frame.
//
// Frame: start(0), DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits(1). Every FSM step and txd update happens only on a
// baud tick, i.e. the first clk edge after baudclk rises.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baudclk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic [2:0]           state_dbg
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_n;
  logic                 baud_q;
  logic                 tick;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 parity_q, parity_n;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_n;
  logic                 stop_cnt_q, stop_cnt_n;
  logic                 txd_n;
  logic                 accept;
  logic                 load;

  // baudclk is already synchronous to clk, so a single register is enough
  // to find its rising edge.
  assign tick = baudclk & ~baud_q;

  assign accept    = tx_valid & ~hold_full;
  assign tx_ready  = ~hold_full;
  assign tx_busy   = (state_q != IDLE);
  assign state_dbg = state_q;

  always_comb begin
    state_n    = state_q;
    txd_n      = txd;
    shift_n    = shift_q;
    parity_n   = parity_q;
    bit_cnt_n  = bit_cnt_q;
    stop_cnt_n = stop_cnt_q;
    load       = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (hold_full) begin
            load    = 1'b1;
            txd_n   = 1'b0;
            state_n = START;
          end else begin
            txd_n = 1'b1;
          end
        end
        START: begin
          txd_n     = shift_q[0];
          bit_cnt_n = '0;
          state_n   = DATA;
        end
        DATA: begin
          if (bit_cnt_q != LAST_BIT) begin
            // shift_q[1] is the bit that becomes shift_q[0] after this shift
            shift_n   = shift_q >> 1;
            txd_n     = shift_q[1];
            bit_cnt_n = bit_cnt_q + 1'b1;
          end else if (PARITY_EN) begin
            txd_n   = parity_q;
            state_n = PARITY;
          end else begin
            txd_n      = 1'b1;
            stop_cnt_n = 1'b0;
            state_n    = STOP;
          end
        end
        PARITY: begin
          txd_n      = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = STOP;
        end
        STOP: begin
          if (stop_cnt_q != LAST_STOP) begin
            stop_cnt_n = stop_cnt_q + 1'b1;
          end else if (hold_full) begin
            // chain straight into the next frame with no idle gap
            load    = 1'b1;
            txd_n   = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    // Parity is taken from the whole word while it is still intact.
    if (load) begin
      shift_n  = hold_q;
      parity_n = (^hold_q) ^ PARITY_ODD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= 1'b0;
      txd        <= 1'b1;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      baud_q     <= baudclk;
      txd        <= txd_n;
      shift_q    <= shift_n;
      parity_q   <= parity_n;
      bit_cnt_q  <= bit_cnt_n;
      stop_cnt_q <= stop_cnt_n;
    end
  end

  // Accept needs an empty holding register and load needs a full one, so
  // the two can never happen on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_q    <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_q    <= tx_data;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx.
// Four instances cover 8N1, 8E1, 8O1 and 8N2. baudclk has a period of four
// clk cycles, so every serial bit lasts four clk cycles.
module tb_uart_tx;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       baudclk = 1'b0;
  logic [3:0] tx_valid = 4'b0000;
  logic [7:0] tx_data [4];
  wire  [3:0] txd;
  wire  [3:0] tx_ready;
  wire  [3:0] tx_busy;
  wire  [2:0] st0, st1, st2, st3;

  int checks = 0;
  int errors = 0;

  // instance configuration as seen by the reference model
  int cfg_par_en [4] = '{0, 1, 1, 0};
  int cfg_odd    [4] = '{0, 0, 1, 0};
  int cfg_stop   [4] = '{1, 1, 1, 2};

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         len;
    logic [15:0] bits;     // bit i = i-th bit on the line
    int         inj_bit;   // frame bit during which the next word is offered, -1 = none
    logic [7:0] inj_data;
  } vec_t;

  vec_t vecs [7];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #6;
    forever begin
      baudclk = ~baudclk;
      #20;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_8n1 (
    .clk(clk), .reset(reset), .baudclk(baudclk), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .txd(txd[0]), .tx_busy(tx_busy[0]), .state_dbg(st0));
  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_8e1 (
    .clk(clk), .reset(reset), .baudclk(baudclk), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .txd(txd[1]), .tx_busy(tx_busy[1]), .state_dbg(st1));
  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_8o1 (
    .clk(clk), .reset(reset), .baudclk(baudclk), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .txd(txd[2]), .tx_busy(tx_busy[2]), .state_dbg(st2));
  uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_8n2 (
    .clk(clk), .reset(reset), .baudclk(baudclk), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .txd(txd[3]), .tx_busy(tx_busy[3]), .state_dbg(st3));

  // ---------------- reference model ----------------
  function automatic int build_frame(input int idx, input logic [7:0] d, output logic [15:0] bits);
    int n;
    n    = 0;
    bits = '0;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < 8; i++) begin
      bits[n] = d[i];
      n++;
    end
    if (cfg_par_en[idx] != 0) begin
      bits[n] = (^d) ^ (cfg_odd[idx] != 0);
      n++;
    end
    for (int i = 0; i < cfg_stop[idx]; i++) begin
      bits[n] = 1'b1;
      n++;
    end
    return n;
  endfunction

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input int idx, input string tag);
    checks++;
    if (txd[idx] !== 1'b1 || tx_busy[idx] !== 1'b0 || tx_ready[idx] !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_after_frame: got txd=%b busy=%b ready=%b expected txd=1 busy=0 ready=1",
               tag, txd[idx], tx_busy[idx], tx_ready[idx]);
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge with the holding register empty; returns one negedge later.
  task automatic send(input int idx, input logic [7:0] d);
    tx_data[idx]  = d;
    tx_valid[idx] = 1'b1;
    @(posedge clk);
    #1;
    tx_valid[idx] = 1'b0;
    tx_data[idx]  = 8'hxx;
    @(negedge clk);
    check($sformatf("ready_low_after_accept[%0d]", idx), tx_ready[idx], 1'b0);
  endtask

  // The start bit must appear on the first tick after acceptance (<= 4 clk).
  task automatic wait_start(input int idx);
    int n;
    n = 0;
    while (txd[idx] !== 1'b0 && n < 4) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("start_within_one_tick[%0d]", idx), txd[idx], 1'b0);
  endtask

  // Entered at the first negedge of the start bit; returns at the negedge
  // just after the last stop bit.
  task automatic check_frame(input int idx, input logic [15:0] bits, input int len,
                             input int inj_bit, input logic [7:0] inj_data, input string tag);
    logic       exp_ready;
    logic       exp_ready_seen;
    int         bad;
    logic [2:0] got;
    exp_ready = 1'b1;
    for (int j = 0; j < len; j++) begin
      bad = 0;
      got = 3'b000;
      exp_ready_seen = exp_ready;
      for (int c = 0; c < 4; c++) begin
        if (txd[idx] !== bits[j] || tx_busy[idx] !== 1'b1 || tx_ready[idx] !== exp_ready) begin
          if (bad == 0) begin
            got = {txd[idx], tx_busy[idx], tx_ready[idx]};
            exp_ready_seen = exp_ready;
          end
          bad++;
        end
        if (j == inj_bit && c == 1) begin
          send(idx, inj_data);
          exp_ready = 1'b0;
        end else begin
          @(negedge clk);
        end
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s bit%0d: got txd,busy,ready=%b expected %b1%b",
                 tag, j, got, bits[j], exp_ready_seen);
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int         bad;
    int         chained;
    int         idx;
    int         len;
    int         len2;
    int         inj;
    logic [7:0] d;
    logic [7:0] d2;
    logic [15:0] bits;
    logic [15:0] bits2;

    for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;

    // reset asserted between clk edges: outputs must respond at once
    #2 reset = 1'b1;
    #1;
    check("reset_async_txd", txd, 4'hF);
    check("reset_async_ready", tx_ready, 4'hF);
    check("reset_async_busy", tx_busy, 4'h0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (txd !== 4'hF || tx_ready !== 4'hF || tx_busy !== 4'h0) bad++;
    end
    check("reset_hold_with_baudclk", bad, 0);
    check("reset_state_idle", {st0, st1, st2, st3}, 12'h000);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // table-driven frames (expected line bits written out by hand)
    vecs[0] = '{0, 8'hA5, 10, 16'h034A, -1, 8'h00};  // 8N1 0xA5
    vecs[1] = '{0, 8'h00, 10, 16'h0200,  4, 8'hFF};  // 8N1 0x00, 0xFF offered while busy
    vecs[2] = '{0, 8'hFF, 10, 16'h03FE, -1, 8'h00};  // chained 0xFF
    vecs[3] = '{1, 8'h07, 11, 16'h060E, -1, 8'h00};  // 8E1 0x07, parity 1
    vecs[4] = '{2, 8'h07, 11, 16'h040E, -1, 8'h00};  // 8O1 0x07, parity 0
    vecs[5] = '{3, 8'h80, 11, 16'h0700,  9, 8'h81};  // 8N2 0x80, next offered in stop bit 1
    vecs[6] = '{3, 8'h81, 11, 16'h0702, -1, 8'h00};  // chained 0x81
    chained = 0;
    for (int v = 0; v < 7; v++) begin
      if (chained == 0) begin
        send(vecs[v].idx, vecs[v].data);
        wait_start(vecs[v].idx);
      end
      check_frame(vecs[v].idx, vecs[v].bits, vecs[v].len, vecs[v].inj_bit, vecs[v].inj_data,
                  $sformatf("vec%0d", v));
      chained = (vecs[v].inj_bit >= 0) ? 1 : 0;
      if (chained == 0) check_idle(vecs[v].idx, $sformatf("vec%0d", v));
    end

    // reset during data bit 3 with a word waiting in the holding register
    send(0, 8'h00);
    wait_start(0);
    repeat (6) @(negedge clk);
    send(0, 8'h5A);
    repeat (10) @(negedge clk);
    check("midframe_txd_bit3", txd[0], 1'b0);
    check("midframe_busy", tx_busy[0], 1'b1);
    #2 reset = 1'b1;
    #1;
    check("midframe_reset_txd", txd[0], 1'b1);
    check("midframe_reset_ready", tx_ready[0], 1'b1);
    check("midframe_reset_busy", tx_busy[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (24) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || tx_busy[0] !== 1'b0 || tx_ready[0] !== 1'b1) bad++;
    end
    check("held_word_discarded", bad, 0);
    send(0, 8'h3C);
    wait_start(0);
    len = build_frame(0, 8'h3C, bits);
    check_frame(0, bits, len, -1, 8'h00, "after_reset_3C");
    check_idle(0, "after_reset_3C");

    // randomized frames against the model, half of them back-to-back
    for (int r = 0; r < 16; r++) begin
      idx = $urandom_range(0, 3);
      d   = 8'($urandom_range(0, 255));
      d2  = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      len = build_frame(idx, d, bits);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 2) : -1;
      send(idx, d);
      wait_start(idx);
      check_frame(idx, bits, len, inj, d2, $sformatf("rand%0d", r));
      if (inj >= 0) begin
        len2 = build_frame(idx, d2, bits2);
        check_frame(idx, bits2, len2, -1, 8'h00, $sformatf("rand%0d_next", r));
      end
      check_idle(idx, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-003 Parameter PARITY_EN, default 0, 1 = parity bit inserted after the data bits.
REQ-004 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 baudclk  input  1  divided bit-rate clock, registered in the clk domain, 50% duty; one bit period = one full baudclk cycle.
REQ-008 tx_data  input  DATA_BITS  byte to transmit, sent LSB first.
REQ-009 tx_valid  input  1  tx_data is valid.
REQ-010 tx_ready  output  1  holding register empty, so a byte can be accepted.
REQ-011 txd  output  1  serial line, registered, idle high.
REQ-012 tx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The block SHALL register baudclk into baud_q and form tick = baudclk & ~baud_q; it SHALL add no synchronizer, because baudclk is already in the clk domain.
REQ-014 All FSM transitions and txd updates SHALL occur only on clk edges where tick=1, so txd changes one clk after baudclk rises.
REQ-015 Acceptance SHALL occur on any clk edge with tx_valid & tx_ready: tx_data is copied to the holding register and tx_ready falls on the next cycle; the acceptance edge does not need a tick.
REQ-016 tx_ready SHALL equal ~hold_full.
REQ-017 tx_data SHALL be ignored whenever tx_ready=0.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-019 IDLE, tick, hold_full: hold moves to the shift register, hold_full clears, txd<=0, next state START; IDLE without hold_full: txd held at 1.
REQ-020 START, tick: txd<=shift[0], bit_cnt<=0, next state DATA.
REQ-021 DATA, tick, bit_cnt<DATA_BITS-1: shift right, txd<=next bit, bit_cnt++.
REQ-022 DATA, tick, bit_cnt=DATA_BITS-1 with PARITY_EN=1: txd<=parity bit, next state PARITY.
REQ-023 DATA, tick, bit_cnt=DATA_BITS-1 with PARITY_EN=0: txd<=1, stop_cnt<=0, next state STOP.
REQ-024 Parity bit SHALL be the XOR of all data bits, inverted when PARITY_ODD=1, computed from the byte at load time.
REQ-025 PARITY, tick: txd<=1, stop_cnt<=0, next state STOP.
REQ-026 STOP, tick, stop_cnt<STOP_BITS-1: stop_cnt++, txd stays 1.
REQ-027 STOP, tick, last stop bit, hold_full: load the byte, txd<=0, next state START, so back-to-back frames have no idle gap.
REQ-028 STOP, tick, last stop bit, hold empty: next state IDLE.
REQ-029 Acceptance and load cannot coincide, because acceptance needs hold empty and load needs hold full; the design SHALL need no arbitration.
REQ-030 Frame length SHALL be 1 + DATA_BITS + PARITY_EN + STOP_BITS ticks.
REQ-031 The first start-bit edge SHALL occur on the first tick after acceptance while in IDLE.

Reset
REQ-032 On reset assertion, outputs SHALL take these values immediately, without waiting for clk: txd=1, tx_busy=0, tx_ready=1.
REQ-033 Reset SHALL also set state=IDLE, hold_full=0, baud_q=0 and bit_cnt=stop_cnt=0.
REQ-034 Reset mid-frame SHALL abort the frame with no completion of the remaining bits, and SHALL discard any held byte.
REQ-035 The first tick after reset release SHALL be the first baudclk rise seen with baud_q=0.

Verification (DIVISOR=2, tick every 4 clk)
REQ-036 Reset: assert reset with baudclk toggling -> txd=1, tx_ready=1, tx_busy=0 throughout.
REQ-037 8N1 frame: send 0xA5 -> txd per tick = 0,1,0,1,0,0,1,0,1,1; each bit lasts 4 clk; tx_busy high for 40 clk, then IDLE.
REQ-038 Back-to-back: send 0x00, then 0xFF while busy -> tx_ready falls after each accept and rises at the START load; the 0xFF start bit immediately follows the 0x00 stop bit.
REQ-039 Parity: 0x07 with PARITY_EN=1 -> parity bit 1 when PARITY_ODD=0 and 0 when PARITY_ODD=1; frame is 11 ticks.
REQ-040 STOP_BITS=2 with 0x80 -> two high stop periods (8 clk) before IDLE or the next start bit.
REQ-041 Reset mid-frame during data bit 3 with hold full -> txd=1 at once, tx_ready=1; next byte 0x3C transmits correctly.
